// File: rtl/wave_scheduler_pkg.sv
// Shared types for the game-level wave scheduler: phases, alien descriptor,
// and the constants both the scheduler and descriptor generator rely on.
package wave_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPAWN      = 3'd1,
    WAIT_CLEAR = 3'd2,
    INTER      = 3'd3,
    OVER       = 3'd4
  } SchedPhase;

  typedef enum logic [1:0] {TYPE0, TYPE1, TYPE2, TYPE3} AlienType;
  typedef enum logic [1:0] {INACTIVE, ACTIVE, HIT, DEAD} AlienState;

  typedef struct packed {
    logic [7:0] _r;
    logic [8:0] _theta;
    AlienType   _type;
    logic [1:0] _hp;
    AlienState  _state;
    logic [7:0] _frame_num;
  } Alien;

  localparam int          OBJ_LIMIT = 8;
  localparam logic [7:0]  R_LIMIT   = 8'd200;
  localparam logic [1:0]  HP_MAX    = 2'd3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Raw 9-bit LFSR slice is at most 511, so one subtraction lands in 0..359.
  function automatic logic [8:0] wrap_theta(input logic [8:0] t);
    return (t >= 9'd360) ? t - 9'd360 : t;
  endfunction

endpackage

// File: rtl/wave_scheduler_alien_generator.sv
// Free-running LFSR that turns into an alien descriptor, captured only on
// the frame a spawn is issued so the output holds between spawns.
module wave_scheduler_alien_generator
  import wave_scheduler_pkg::*;
(
  input  logic                     clk_frame,
  input  logic                     rst,
  input  logic [3:0]               level_i,
  input  logic                     take_i,
  output logic [$bits(Alien)-1:0]  alien_o
);

  logic [15:0] lfsr_q, lfsr_d;
  Alien        alien_q, alien_d;
  logic [2:0]  hp_sum;

  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    hp_sum  = 3'd1 + {1'b0, level_i[3:2]};
    alien_d = alien_q;
    alien_d._r     = R_LIMIT;
    alien_d._theta = wrap_theta(lfsr_q[8:0]);
    if (level_i < 4'd2)
      alien_d._type = AlienType'({1'b0, lfsr_q[9]});
    else if (level_i < 4'd4)
      alien_d._type = (lfsr_q[10:9] == 2'd3) ? TYPE2 : AlienType'(lfsr_q[10:9]);
    else
      alien_d._type = AlienType'(lfsr_q[10:9]);
    alien_d._hp        = (hp_sum > {1'b0, HP_MAX}) ? HP_MAX : hp_sum[1:0];
    alien_d._state     = ACTIVE;
    alien_d._frame_num = '0;
  end

  always_ff @(posedge clk_frame or posedge rst) begin
    if (rst) begin
      lfsr_q  <= LFSR_SEED;
      alien_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      if (take_i) alien_q <= alien_d;
    end
  end

  assign alien_o = alien_q;

endmodule

// File: rtl/wave_scheduler.sv
// Game-level sequencer: gates the event core, paces alien spawns per wave,
// waits for the wave to clear, and advances levels until game over.
module wave_scheduler
  import wave_scheduler_pkg::*;
#(
  parameter int MAX_ACTIVE   = 8,
  parameter int WAVE_BASE    = 4,
  parameter int SPAWN_GAP    = 32,
  parameter int INTER_FRAMES = 90,
  parameter int LEVEL_MAX    = 15,
  parameter int SETTLE       = 3
) (
  input  logic                     clk_frame,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     all_clear_i,
  input  logic                     game_over_i,
  input  logic [3:0]               object_count_i,
  output logic                     en_core_o,
  output logic                     core_rst_o,
  output logic                     spawn_object_o,
  output logic [$bits(Alien)-1:0]  spawn_data_o,
  output logic [3:0]               level_o,
  output logic [2:0]               phase_o
);

  localparam int GW = $clog2(SPAWN_GAP) + 1;
  localparam int IW = $clog2(INTER_FRAMES) + 1;
  localparam int SW = $clog2(SETTLE) + 1;

  SchedPhase       state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [4:0]      spawned_q, spawned_d;
  logic [IW-1:0]   inter_q, inter_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [3:0]      level_q, level_d;
  logic            en_core_q, en_core_d;
  logic            core_rst_q, core_rst_d;
  logic            spawn_q, spawn_d;
  logic [4:0]      wave_size;
  logic            room;

  assign wave_size = 5'(WAVE_BASE) + {1'b0, level_q};
  assign room      = {1'b0, object_count_i} < 5'(MAX_ACTIVE);

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    spawned_d  = spawned_q;
    inter_d    = inter_q;
    settle_d   = settle_q;
    level_d    = level_q;
    core_rst_d = 1'b0;
    spawn_d    = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_i) begin
          core_rst_d = 1'b1;
          level_d    = '0;
          gap_d      = '0;
          spawned_d  = '0;
          state_d    = SPAWN;
        end
      end
      SPAWN: begin
        // Game over wins over a due spawn: no pulse in the frame we leave.
        if (game_over_i) begin
          state_d = OVER;
        end else if (spawned_q == wave_size) begin
          spawned_d = '0;
          settle_d  = '0;
          state_d   = WAIT_CLEAR;
        end else if (gap_q == '0) begin
          if (room) begin
            spawn_d   = 1'b1;
            spawned_d = spawned_q + 5'd1;
            gap_d     = GW'(1);
          end
        end else begin
          gap_d = (gap_q == GW'(SPAWN_GAP - 1)) ? '0 : gap_q + GW'(1);
        end
      end
      WAIT_CLEAR: begin
        // all_clear lags the last spawn through the core, so ignore it briefly.
        if (game_over_i)
          state_d = OVER;
        else if (settle_q < SW'(SETTLE))
          settle_d = settle_q + SW'(1);
        else if (all_clear_i) begin
          inter_d = '0;
          state_d = INTER;
        end
      end
      INTER: begin
        if (game_over_i) begin
          state_d = OVER;
        end else if (inter_q == IW'(INTER_FRAMES - 1)) begin
          inter_d = '0;
          gap_d   = '0;
          level_d = (level_q >= 4'(LEVEL_MAX)) ? 4'(LEVEL_MAX) : level_q + 4'd1;
          state_d = SPAWN;
        end else begin
          inter_d = inter_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    en_core_d = (state_d == SPAWN) || (state_d == WAIT_CLEAR) || (state_d == INTER);
  end

  always_ff @(posedge clk_frame or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      spawned_q  <= '0;
      inter_q    <= '0;
      settle_q   <= '0;
      level_q    <= '0;
      en_core_q  <= 1'b0;
      core_rst_q <= 1'b0;
      spawn_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      spawned_q  <= spawned_d;
      inter_q    <= inter_d;
      settle_q   <= settle_d;
      level_q    <= level_d;
      en_core_q  <= en_core_d;
      core_rst_q <= core_rst_d;
      spawn_q    <= spawn_d;
    end
  end

  wave_scheduler_alien_generator u_alien_generator (
    .clk_frame (clk_frame),
    .rst       (rst),
    .level_i   (level_q),
    .take_i    (spawn_d),
    .alien_o   (spawn_data_o)
  );

  assign en_core_o      = en_core_q;
  assign core_rst_o     = core_rst_q;
  assign spawn_object_o = spawn_q;
  assign level_o        = level_q;
  assign phase_o        = state_q;

endmodule

// File: tb/tb_wave_scheduler.sv
// Directed bench for wave_scheduler: spawn pacing, backpressure, settle and
// intermission timing, level saturation, game over, restart and reset.
module tb_wave_scheduler;
  import wave_scheduler_pkg::*;

  logic clk_frame = 1'b0;
  logic rst, start, all_clear, game_over;
  logic [3:0] object_count;
  logic en_core, core_rst, spawn_object;
  logic [$bits(Alien)-1:0] spawn_data;
  logic [3:0] level;
  logic [2:0] phase;

  Alien sd, last;
  int   total = 0, bad = 0, fr = 0, npulse = 0, guard = 0, n = 0;
  bit   saw_t3_hi = 1'b0;

  assign sd = Alien'(spawn_data);

  wave_scheduler dut (
    .clk_frame      (clk_frame),
    .rst            (rst),
    .start_i        (start),
    .all_clear_i    (all_clear),
    .game_over_i    (game_over),
    .object_count_i (object_count),
    .en_core_o      (en_core),
    .core_rst_o     (core_rst),
    .spawn_object_o (spawn_object),
    .spawn_data_o   (spawn_data),
    .level_o        (level),
    .phase_o        (phase)
  );

  always #5 clk_frame = ~clk_frame;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h frame=%0d", tag, got, exp, fr);
    end
  endtask

  function automatic logic [31:0] exp_hp(input logic [3:0] l);
    if (l >= 4'd8) return 32'd3;
    if (l >= 4'd4) return 32'd2;
    return 32'd1;
  endfunction

  function automatic logic [31:0] type_ok(input logic [3:0] l, input AlienType t);
    if (l < 4'd2) return {31'd0, (t == TYPE0) || (t == TYPE1)};
    if (l < 4'd4) return {31'd0, t != TYPE3};
    return 32'd1;
  endfunction

  // One frame: step past the edge, then audit the descriptor output.
  task automatic tick();
    @(posedge clk_frame); #1;
    fr++;
    if (spawn_object) begin
      npulse++;
      chk("theta_range", {31'd0, sd._theta <= 9'd359}, 32'd1);
      chk("r_limit", sd._r, R_LIMIT);
      chk("state_active", sd._state, ACTIVE);
      chk("frame_num", sd._frame_num, 32'd0);
      chk("hp", sd._hp, exp_hp(level));
      chk("type_limit", type_ok(level, sd._type), 32'd1);
      if (level >= 4'd4 && sd._type == TYPE3) saw_t3_hi = 1'b1;
      last = sd;
    end else begin
      chk("data_hold", spawn_data, last);
    end
  endtask

  task automatic clear_wave(input logic [3:0] exp_level);
    chk("wave_end_phase", phase, WAIT_CLEAR);
    all_clear = 1'b1;
    guard = 0;
    while (phase != INTER && guard < 10) begin tick(); guard++; end
    all_clear = 1'b0;
    chk("enter_inter", phase, INTER);
    n = 0;
    guard = 0;
    while (phase == INTER && guard < 200) begin n++; tick(); guard++; end
    chk("inter_len", n, 32'd90);
    chk("inter_exit", phase, SPAWN);
    chk("level_next", level, exp_level);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; all_clear = 1'b0; game_over = 1'b0; object_count = 4'd0;
    last = '0;
    #12;
    chk("rst_phase", phase, IDLE);
    chk("rst_en_core", en_core, 32'd0);
    chk("rst_core_rst", core_rst, 32'd0);
    chk("rst_spawn", spawn_object, 32'd0);
    chk("rst_level", level, 32'd0);
    chk("rst_data", spawn_data, 32'd0);
    @(negedge clk_frame);
    rst = 1'b0;

    // Frame 0 start; core reset in frame 1, spawns every 32 frames from frame 2.
    start = 1'b1;
    npulse = 0;
    tick();
    start = 1'b0;
    chk("start_core_rst", core_rst, 32'd1);
    chk("start_phase", phase, SPAWN);
    chk("start_en_core", en_core, 32'd1);
    chk("start_level", level, 32'd0);
    for (int f = 2; f <= 98; f++) begin
      tick();
      chk("spawn_timing", spawn_object, {31'd0, (f % 32) == 2});
      if (f == 2) chk("core_rst_once", core_rst, 32'd0);
    end
    tick();
    chk("wave0_count", npulse, 32'd4);
    chk("wave0_wait", phase, WAIT_CLEAR);

    // all_clear ignored for the settle window, honoured on the fourth frame.
    all_clear = 1'b1;
    for (int f = 100; f <= 102; f++) begin
      tick();
      chk("settle_hold", phase, WAIT_CLEAR);
    end
    tick();
    chk("settle_exit", phase, INTER);
    all_clear = 1'b0;
    for (int f = 104; f <= 192; f++) begin
      tick();
      chk("inter_hold", phase, INTER);
    end
    tick();
    chk("inter0_exit", phase, SPAWN);
    chk("level1", level, 32'd1);

    // Level 1 wave with backpressure from a full object table.
    npulse = 0;
    tick();
    chk("l1_first_spawn", spawn_object, 32'd1);
    while (fr < 220) tick();
    object_count = 4'd8;
    for (int f = 221; f <= 236; f++) begin
      tick();
      chk("full_no_spawn", spawn_object, 32'd0);
      chk("full_phase", phase, SPAWN);
    end
    object_count = 4'd7;
    tick();
    chk("room_spawn", spawn_object, 32'd1);
    object_count = 4'd0;
    guard = 0;
    while (phase == SPAWN && guard < 300) begin tick(); guard++; end
    chk("wave1_count", npulse, 32'd5);
    clear_wave(4'd2);

    // Play through to the top level; the last clear must not wrap.
    for (int lv = 2; lv <= 15; lv++) begin
      npulse = 0;
      guard = 0;
      while (phase == SPAWN && guard < 1000) begin tick(); guard++; end
      chk("wave_count", npulse, 32'(4 + lv));
      clear_wave((lv == 15) ? 4'd15 : 4'(lv + 1));
    end
    chk("level_sat", level, 32'd15);
    chk("saw_type3", {31'd0, saw_t3_hi}, 32'd1);

    // First SPAWN frame: a spawn is due next edge, game over must win.
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    chk("over_phase", phase, OVER);
    chk("over_spawn", spawn_object, 32'd0);
    chk("over_en_core", en_core, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("over_frozen", phase, OVER);
      chk("over_level", level, 32'd15);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_core_rst", core_rst, 32'd1);
    chk("restart_level", level, 32'd0);
    chk("restart_phase", phase, SPAWN);
    tick();
    chk("restart_spawn", spawn_object, 32'd1);

    // Async reset while a spawn pulse is on the outputs.
    rst = 1'b1;
    #1;
    last = '0;
    chk("midrst_phase", phase, IDLE);
    chk("midrst_spawn", spawn_object, 32'd0);
    chk("midrst_en_core", en_core, 32'd0);
    chk("midrst_core_rst", core_rst, 32'd0);
    chk("midrst_level", level, 32'd0);
    chk("midrst_data", spawn_data, 32'd0);
    @(negedge clk_frame);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", phase, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
